// File: rtl/pc_fetch_queue.sv
// Fetch front end: fetch PC generation, one-outstanding I-cache request/response
// handshake, and a DEPTH-entry instruction FIFO decoupling IF from ID.
module pc_fetch_queue #(
    parameter logic [31:0] PC_INITIAL   = 32'hbfc00000,
    parameter logic [31:0] PC_EXCEPTION = 32'hbfc00380,
    parameter int          DEPTH        = 4,
    parameter int          DATA_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              exc_req,
    input  logic              ex_branch_taken,
    input  logic [31:0]       ex_branch_target,
    input  logic              id_jump_valid,
    input  logic [31:0]       id_jump_target,
    output logic              cache_req,
    output logic [31:0]       cache_addr,
    input  logic              cache_ack,
    input  logic              cache_rvalid,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_plus_4,
    output logic [DATA_W-1:0] if_instr,
    input  logic              id_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       fetch_pc_reg, fetch_pc_next;
    logic [31:0]       pend_pc_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [31:0]       pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic              redirect;
    logic [31:0]       redirect_target;
    logic              credit;
    logic              push;
    logic              pop;

    assign redirect        = exc_req | ex_branch_taken | id_jump_valid;
    assign redirect_target = exc_req         ? PC_EXCEPTION :
                             ex_branch_taken ? ex_branch_target : id_jump_target;
    // An outstanding WAIT response already owns one FIFO slot.
    assign credit = (count_reg + CNT_W'(state_reg == ST_WAIT)) < CNT_W'(DEPTH);
    assign push   = (state_reg == ST_WAIT) && cache_rvalid && !redirect;
    assign pop    = if_valid && id_ready && enable && !redirect;

    assign cache_req    = (state_reg == ST_REQ);
    assign cache_addr   = fetch_pc_reg;
    assign if_valid     = (count_reg != '0);
    assign if_pc        = pc_mem[rd_ptr_reg];
    assign if_instr     = instr_mem[rd_ptr_reg];
    assign if_pc_plus_4 = if_pc + 32'd4;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (redirect) begin
            fetch_pc_next = redirect_target;
        end
        case (state_reg)
            ST_IDLE: begin
                if (enable && (redirect || credit)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cache_ack) begin
                    if (redirect) begin
                        state_next = ST_DROP;
                    end else begin
                        state_next    = ST_WAIT;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end
                end
            end
            ST_WAIT: begin
                if (cache_rvalid) begin
                    state_next = (enable && (redirect || credit)) ? ST_REQ : ST_IDLE;
                end else if (redirect) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (cache_rvalid) begin
                    state_next = enable ? ST_REQ : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= PC_INITIAL;
            pend_pc_reg  <= PC_INITIAL;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            if ((state_reg == ST_REQ) && cache_ack) begin
                pend_pc_reg <= fetch_pc_reg;
            end
        end
    end

    // A redirect flushes the queue; pointers restart at slot 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    pc_mem[gi]    <= '0;
                    instr_mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    pc_mem[gi]    <= pend_pc_reg;
                    instr_mem[gi] <= cache_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed self-checking bench for pc_fetch_queue: ordered fetch, backpressure,
// redirects with priority, push+pop, PC wrap and asynchronous reset mid-fetch.
module tb_pc_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        exc_req;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_jump_valid;
    logic [31:0] id_jump_target;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic        cache_ack;
    logic        cache_rvalid;
    logic [31:0] cache_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instr;
    logic        id_ready;

    int tests = 0;
    int fails = 0;

    pc_fetch_queue dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable           (enable),
        .exc_req          (exc_req),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_jump_valid    (id_jump_valid),
        .id_jump_target   (id_jump_target),
        .cache_req        (cache_req),
        .cache_addr       (cache_addr),
        .cache_ack        (cache_ack),
        .cache_rvalid     (cache_rvalid),
        .cache_rdata      (cache_rdata),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_pc_plus_4     (if_pc_plus_4),
        .if_instr         (if_instr),
        .id_ready         (id_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s: got %h expected %h", tag, obs, exp);
    endtask

    // Ack in the current REQ cycle, then return rdata two cycles later.
    task automatic fetch_one(input logic [31:0] data);
        cache_ack = 1'b1;
        tick();
        cache_ack = 1'b0;
        tick();
        cache_rvalid = 1'b1;
        cache_rdata  = data;
        tick();
        cache_rvalid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b1; exc_req = 1'b0; ex_branch_taken = 1'b0;
        ex_branch_target = '0; id_jump_valid = 1'b0; id_jump_target = '0;
        cache_ack = 1'b0; cache_rvalid = 1'b0; cache_rdata = '0; id_ready = 1'b0;
        tick();
        tick();
        chk("rst_req",      {31'd0, cache_req}, 32'd0);
        chk("rst_addr",     cache_addr,         32'hbfc00000);
        chk("rst_valid",    {31'd0, if_valid},  32'd0);
        chk("rst_pc",       if_pc,              32'd0);
        chk("rst_instr",    if_instr,           32'd0);
        chk("rst_pc4",      if_pc_plus_4,       32'd4);
        resetn = 1'b1;
        tick();

        // Ordered fetch with ID stalled: exactly four entries fill the queue
        for (int k = 0; k < 4; k++) begin
            chk("seq_req",  {31'd0, cache_req}, 32'd1);
            chk("seq_addr", cache_addr, 32'hbfc00000 + 32'(4 * k));
            fetch_one(32'h1000_0000 + 32'(k));
            chk("seq_head_pc", if_pc, 32'hbfc00000);
        end
        chk("full_req_off", {31'd0, cache_req}, 32'd0);
        tick();
        chk("full_req_hold", {31'd0, cache_req}, 32'd0);
        chk("full_instr", if_instr, 32'h1000_0000);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("pop1_pc",    if_pc,    32'hbfc00004);
        chk("pop1_instr", if_instr, 32'h1000_0001);
        chk("pop1_req",   {31'd0, cache_req}, 32'd0);
        tick();
        chk("resume_req",  {31'd0, cache_req}, 32'd1);
        chk("resume_addr", cache_addr, 32'hbfc00010);

        // Push and pop in the same cycle with two entries queued
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("pop2_pc", if_pc, 32'hbfc00008);
        cache_ack = 1'b1;
        tick();
        cache_ack = 1'b0;
        tick();
        cache_rvalid = 1'b1; cache_rdata = 32'h1000_0004; id_ready = 1'b1;
        tick();
        cache_rvalid = 1'b0; id_ready = 1'b0;
        chk("pp_pc",    if_pc,    32'hbfc0000c);
        chk("pp_instr", if_instr, 32'h1000_0003);
        chk("pp_addr",  cache_addr, 32'hbfc00014);
        id_ready = 1'b1;
        tick();
        chk("pp_pc2",    if_pc,    32'hbfc00010);
        chk("pp_instr2", if_instr, 32'h1000_0004);
        chk("pp_valid2", {31'd0, if_valid}, 32'd1);
        tick();
        id_ready = 1'b0;
        chk("pp_empty", {31'd0, if_valid}, 32'd0);

        // EX branch while waiting for the response: stale data dropped
        cache_ack = 1'b1;
        tick();
        cache_ack = 1'b0;
        ex_branch_taken = 1'b1; ex_branch_target = 32'h80001000;
        tick();
        ex_branch_taken = 1'b0;
        chk("drop_req", {31'd0, cache_req}, 32'd0);
        cache_rvalid = 1'b1; cache_rdata = 32'hdead_beef;
        tick();
        cache_rvalid = 1'b0;
        chk("drop_valid", {31'd0, if_valid}, 32'd0);
        chk("drop_req2",  {31'd0, cache_req}, 32'd1);
        chk("drop_addr",  cache_addr, 32'h80001000);
        fetch_one(32'h2000_0005);
        chk("br_pc",    if_pc,    32'h80001000);
        chk("br_instr", if_instr, 32'h2000_0005);
        chk("br_addr",  cache_addr, 32'h80001004);

        // Simultaneous redirects: exception wins, queue flushed, pop suppressed
        exc_req = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h12340000;
        id_jump_valid = 1'b1; id_jump_target = 32'h56780000; id_ready = 1'b1;
        tick();
        exc_req = 1'b0; id_ready = 1'b0;
        chk("exc_addr",  cache_addr, 32'hbfc00380);
        chk("exc_valid", {31'd0, if_valid}, 32'd0);
        tick();
        ex_branch_taken = 1'b0;
        chk("ex_over_id", cache_addr, 32'h12340000);
        tick();
        chk("id_jump", cache_addr, 32'h56780000);
        id_jump_target = 32'hfffffffc;
        tick();
        id_jump_valid = 1'b0;
        chk("wrap_addr", cache_addr, 32'hfffffffc);
        fetch_one(32'h3000_0006);
        chk("wrap_pc",   if_pc,        32'hfffffffc);
        chk("wrap_pc4",  if_pc_plus_4, 32'h00000000);
        chk("wrap_next", cache_addr,   32'h00000000);

        // Asynchronous reset in WAIT; late response after release is ignored
        cache_ack = 1'b1;
        tick();
        cache_ack = 1'b0;
        resetn = 1'b0;
        #1;
        chk("arst_req",   {31'd0, cache_req}, 32'd0);
        chk("arst_addr",  cache_addr, 32'hbfc00000);
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_pc",    if_pc, 32'd0);
        chk("arst_instr", if_instr, 32'd0);
        chk("arst_pc4",   if_pc_plus_4, 32'd4);
        tick();
        resetn = 1'b1;
        cache_rvalid = 1'b1; cache_rdata = 32'hbad0_bad0;
        tick();
        cache_rvalid = 1'b0;
        chk("late_valid", {31'd0, if_valid}, 32'd0);
        chk("late_req",   {31'd0, cache_req}, 32'd1);
        chk("late_addr",  cache_addr, 32'hbfc00000);

        // enable low blocks the pop
        fetch_one(32'h4000_0007);
        chk("en_pc", if_pc, 32'hbfc00000);
        enable = 1'b0; id_ready = 1'b1;
        tick();
        chk("en0_valid", {31'd0, if_valid}, 32'd1);
        chk("en0_pc",    if_pc, 32'hbfc00000);
        enable = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("en1_valid", {31'd0, if_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
